// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic operand feeder and its skew lanes.
package systolic_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_N          = 4;

   localparam logic LD_SEL_A = 1'b0;
   localparam logic LD_SEL_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } feeder_state_t;

   function automatic int stream_len(input int n);
      return 2 * n - 1;
   endfunction

   function automatic int drain_len(input int n);
      return n - 1;
   endfunction

   // Step counter must reach 3N-3 without wrapping.
   function automatic int step_width(input int n);
      return $clog2(3 * n);
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Tile load channel into the systolic feeder: one A row or one B column per beat.
interface systolic_feeder_if
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int N          = DEF_N
);
   // A beat transfers on a rising clk edge where ld_valid && ld_ready; the
   // master holds sel/idx/data stable while ld_valid is high and ld_ready is low.
   logic                    ld_valid;
   logic                    ld_ready;
   logic                    ld_sel;
   logic [$clog2(N)-1:0]    ld_idx;
   logic [N*DATA_WIDTH-1:0] ld_data;

   modport master (output ld_valid, output ld_sel, output ld_idx, output ld_data,
                   input  ld_ready);
   modport slave  (input  ld_valid, input  ld_sel, input  ld_idx, input  ld_data,
                   output ld_ready);
endinterface

// File: rtl/systolic_skew_lane.sv
// One skew lane: picks element (t - idx) of a buffered vector, or 0 outside the diagonal window.
module systolic_skew_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4,
   parameter int TW         = 4,
   parameter int IW         = $clog2(N)
)(
   input  logic [IW-1:0]           idx,
   input  logic [TW-1:0]           t,
   input  logic [N*DATA_WIDTH-1:0] vec,
   output logic [DATA_WIDTH-1:0]   sel
);

   logic [DATA_WIDTH-1:0] elem [N];
   logic [TW-1:0]         k;

   for (genvar e = 0; e < N; e++) begin : g_elem
      assign elem[e] = vec[e*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      sel = '0;
      k   = t - TW'(idx);
      if ((t >= TW'(idx)) && (k < TW'(N))) sel = elem[k[IW-1:0]];
   end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers an N x N tile of A and B and streams them diagonally skewed into a PE grid.
// Optional SYSTOLIC_FEEDER_ACCUM_EN adds an accumulate input that skips the PE clear.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int N          = DEF_N
)(
   input  logic                    clk,
   input  logic                    reset,
   systolic_feeder_if.slave        ld,
   input  logic                    start,
`ifdef SYSTOLIC_FEEDER_ACCUM_EN
   input  logic                    accumulate,
`endif
   output logic                    busy,
   output logic                    done,
   output logic                    array_clr,
   output logic [N*DATA_WIDTH-1:0] a_feed,
   output logic [N*DATA_WIDTH-1:0] b_feed,
   output feeder_state_t           state_dbg
);

   localparam int TW = step_width(N);
   localparam int IW = $clog2(N);
   localparam logic [TW-1:0] T_STREAM_END = TW'(stream_len(N) - 1);
   localparam logic [TW-1:0] T_DRAIN_END  = TW'(stream_len(N) + drain_len(N) - 1);

   feeder_state_t           state, state_n;
   logic [TW-1:0]           t, t_n;
   logic [N*DATA_WIDTH-1:0] a_rows [N];
   logic [N*DATA_WIDTH-1:0] b_cols [N];
   logic [N*DATA_WIDTH-1:0] a_sel, b_sel;
   logic                    skip_clear;
   logic                    ld_fire;

`ifdef SYSTOLIC_FEEDER_ACCUM_EN
   assign skip_clear = accumulate;
`else
   assign skip_clear = 1'b0;
`endif

   assign ld.ld_ready = (state == IDLE);
   assign ld_fire     = ld.ld_valid && ld.ld_ready;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign array_clr   = (state == CLEAR);
   assign state_dbg   = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < N; r++) begin
            a_rows[r] <= '0;
            b_cols[r] <= '0;
         end
      end else if (ld_fire && (int'(ld.ld_idx) < N)) begin
         if (ld.ld_sel == LD_SEL_A) a_rows[ld.ld_idx] <= ld.ld_data;
         else                       b_cols[ld.ld_idx] <= ld.ld_data;
      end
   end

   always_comb begin
      state_n = state;
      t_n     = t;
      unique case (state)
         IDLE: begin
            t_n = '0;
            if (start) state_n = skip_clear ? STREAM : CLEAR;
         end
         CLEAR: begin
            t_n     = '0;
            state_n = STREAM;
         end
         STREAM: begin
            t_n = t + 1'b1;
            if (t == T_STREAM_END) state_n = DRAIN;
         end
         DRAIN: begin
            t_n = t + 1'b1;
            if (t == T_DRAIN_END) state_n = DONE;
         end
         DONE: begin
            t_n     = '0;
            state_n = IDLE;
         end
         default: begin
            t_n     = '0;
            state_n = IDLE;
         end
      endcase
   end

   // Lanes look at the next step so the feed registers hold the value for the current t.
   for (genvar i = 0; i < N; i++) begin : g_lane
      systolic_skew_lane #(.DATA_WIDTH(DATA_WIDTH), .N(N), .TW(TW), .IW(IW)) u_a_lane (
         .idx (IW'(i)),
         .t   (t_n),
         .vec (a_rows[i]),
         .sel (a_sel[i*DATA_WIDTH +: DATA_WIDTH])
      );
      systolic_skew_lane #(.DATA_WIDTH(DATA_WIDTH), .N(N), .TW(TW), .IW(IW)) u_b_lane (
         .idx (IW'(i)),
         .t   (t_n),
         .vec (b_cols[i]),
         .sel (b_sel[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         t      <= '0;
         a_feed <= '0;
         b_feed <= '0;
      end else begin
         state  <= state_n;
         t      <= t_n;
         a_feed <= (state_n == STREAM) ? a_sel : '0;
         b_feed <= (state_n == STREAM) ? b_sel : '0;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder driving a behavioural 4x4 PE grid; checks feeds cycle by cycle and final sums.
`timescale 1ns/1ps
module tb_systolic_feeder;
   import systolic_pkg::*;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int LW = N * DW;
   localparam int IW = $clog2(N);
   localparam int W  = 3 + 2 * LW;

   // ---------------- clock / reset / DUT ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
`ifdef SYSTOLIC_FEEDER_ACCUM_EN
   logic accumulate = 1'b0;
`endif
   logic          busy, done, array_clr;
   logic [LW-1:0] a_feed, b_feed;
   feeder_state_t state_dbg;

   always #5 clk = ~clk;

   systolic_feeder_if #(.DATA_WIDTH(DW), .N(N)) ld_if ();

   systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld         (ld_if),
      .start      (start),
`ifdef SYSTOLIC_FEEDER_ACCUM_EN
      .accumulate (accumulate),
`endif
      .busy       (busy),
      .done       (done),
      .array_clr  (array_clr),
      .a_feed     (a_feed),
      .b_feed     (b_feed),
      .state_dbg  (state_dbg)
   );

   // ---------------- behavioural PE grid ----------------
   logic [DW-1:0] pa_flat [N*N];
   logic [DW-1:0] pb_flat [N*N];
   logic [31:0]   c_flat  [N*N];

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [DW-1:0] ain, bin;
         logic [DW-1:0] pa = '0;
         logic [DW-1:0] pb = '0;
         logic [31:0]   c  = '0;
         if (j == 0) begin : g_aw
            assign ain = a_feed[i*DW +: DW];
         end else begin : g_ai
            assign ain = pa_flat[i*N + j - 1];
         end
         if (i == 0) begin : g_bn
            assign bin = b_feed[j*DW +: DW];
         end else begin : g_bi
            assign bin = pb_flat[(i-1)*N + j];
         end
         always @(posedge clk) begin
            pa <= ain;
            pb <= bin;
            if (array_clr) c <= '0;
            else           c <= c + 32'(ain) * 32'(bin);
         end
         assign pa_flat[i*N + j] = pa;
         assign pb_flat[i*N + j] = pb;
         assign c_flat[i*N + j]  = c;
      end
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0]  exp_q [$];
   logic [DW-1:0] a_m [N][N];
   logic [DW-1:0] b_m [N][N];
   int            exp_c [N][N];
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] fill(input int base, input int step);
      logic [LW-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + step * k);
      return v;
   endfunction

   function automatic logic [LW-1:0] onehot_vec(input int pos);
      logic [LW-1:0] v;
      v = '0;
      v[pos*DW +: DW] = DW'(1);
      return v;
   endfunction

   task automatic set_shadow(input logic sel, input int idx, input logic [LW-1:0] data);
      for (int k = 0; k < N; k++) begin
         if (sel == LD_SEL_A) a_m[idx][k] = data[k*DW +: DW];
         else                 b_m[k][idx] = data[k*DW +: DW];
      end
   endtask

   task automatic clear_shadow();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            a_m[i][k] = '0;
            b_m[i][k] = '0;
         end
   endtask

   // ---------------- driver tasks (enter and leave at a negedge) ----------------
   task automatic load(input logic sel, input int idx, input logic [LW-1:0] data);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_sel   = sel;
      ld_if.ld_idx   = IW'(idx);
      ld_if.ld_data  = data;
      check($sformatf("ld_ready_idle_%0d", idx), W'(ld_if.ld_ready), W'(1));
      @(posedge clk);
      @(negedge clk);
      ld_if.ld_valid = 1'b0;
      set_shadow(sel, idx, data);
   endtask

   task automatic run_job(input string name, input bit acc, input int abort_at, input bit poke,
                          input bit co_load, input logic co_sel, input int co_idx,
                          input logic [LW-1:0] co_data);
      int            len;
      int            t;
      int            sum;
      logic [LW-1:0] fa, fb;
      logic [W-1:0]  e;
      len = acc ? 3*N - 1 : 3*N;
      if (co_load) set_shadow(co_sel, co_idx, co_data);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            sum = acc ? exp_c[i][j] : 0;
            for (int k = 0; k < N; k++) sum += int'(a_m[i][k]) * int'(b_m[k][j]);
            exp_c[i][j] = sum;
         end
      for (int c = 1; c <= len; c++) begin
         t  = acc ? c - 1 : c - 2;
         fa = '0;
         fb = '0;
         for (int l = 0; l < N; l++) begin
            if ((t - l >= 0) && (t - l < N)) begin
               fa[l*DW +: DW] = a_m[l][t-l];
               fb[l*DW +: DW] = b_m[t-l][l];
            end
         end
         exp_q.push_back({(!acc && c == 1), 1'b1, (c == len), fa, fb});
      end
      start = 1'b1;
`ifdef SYSTOLIC_FEEDER_ACCUM_EN
      accumulate = acc;
`endif
      if (co_load) begin
         ld_if.ld_valid = 1'b1;
         ld_if.ld_sel   = co_sel;
         ld_if.ld_idx   = IW'(co_idx);
         ld_if.ld_data  = co_data;
      end
      @(posedge clk);
      @(negedge clk);
      start          = 1'b0;
      ld_if.ld_valid = 1'b0;
      for (int c = 1; c <= len; c++) begin
         e = exp_q.pop_front();
         check($sformatf("%s_cyc%0d", name, c), {array_clr, busy, done, a_feed, b_feed}, e);
         if (abort_at == c) begin
            reset = 1'b0;
            break;
         end
         if (poke && c == 2) begin
            ld_if.ld_valid = 1'b1;
            ld_if.ld_sel   = 1'($urandom_range(0, 1));
            ld_if.ld_idx   = IW'($urandom_range(0, N-1));
            ld_if.ld_data  = LW'($urandom);
            start          = 1'b1;
            check($sformatf("%s_ld_ready_busy", name), W'(ld_if.ld_ready), W'(0));
         end
         if (c == len) begin
            start          = 1'b0;
            ld_if.ld_valid = 1'b0;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  check($sformatf("%s_c_%0d_%0d", name, i, j), W'(c_flat[i*N + j]), W'(exp_c[i][j]));
         end
         @(posedge clk);
         @(negedge clk);
      end
      if (abort_at == 0)
         check($sformatf("%s_back_idle", name), {W'(busy), W'(state_dbg)}, {W'(0), W'(IDLE)});
      exp_q.delete();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic seen_done;
      ld_if.ld_valid = 1'b0;
      ld_if.ld_sel   = 1'b0;
      ld_if.ld_idx   = '0;
      ld_if.ld_data  = '0;
      clear_shadow();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) exp_c[i][j] = 0;

      repeat (3) @(negedge clk);
      check("rst_outputs", {array_clr, busy, done, a_feed, b_feed}, '0);
      check("rst_ld_ready", W'(ld_if.ld_ready), W'(1));
      check("rst_state", W'(state_dbg), W'(IDLE));
      reset = 1'b1;
      @(negedge clk);

      // A row 0 = {1,2,3,4}, all else zero: lane 0 streams 1..4 then zeros
      load(LD_SEL_A, 0, fill(1, 1));
      run_job("row0", 1'b0, 0, 1'b0, 1'b0, LD_SEL_A, 0, '0);

      // A all 2, B all 3, with loads and start poked while busy
      for (int r = 0; r < N; r++) begin
         load(LD_SEL_A, r, fill(2, 0));
         load(LD_SEL_B, r, fill(3, 0));
      end
      run_job("ab23_poke", 1'b0, 0, 1'b1, 1'b0, LD_SEL_A, 0, '0);
      run_job("ab23_again", 1'b0, 0, 1'b0, 1'b0, LD_SEL_A, 0, '0);

      // Identity A, B[k][j] = 4k+j+1; last B column arrives in the start cycle
      for (int r = 0; r < N; r++) load(LD_SEL_A, r, onehot_vec(r));
      for (int j = 0; j < N-1; j++) load(LD_SEL_B, j, fill(j + 1, 4));
      run_job("ident", 1'b0, 0, 1'b0, 1'b1, LD_SEL_B, N-1, fill(N, 4));

      // Reset at stream step 3 aborts the job
      run_job("abort", 1'b0, 5, 1'b0, 1'b0, LD_SEL_A, 0, '0);
      #1;
      check("abort_outputs", {array_clr, busy, done, a_feed, b_feed}, '0);
      check("abort_ld_ready", W'(ld_if.ld_ready), W'(1));
      seen_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      reset = 1'b1;
      repeat (3*N) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", W'(seen_done), W'(0));
      check("abort_state", W'(state_dbg), W'(IDLE));
      clear_shadow();

      // Random reload after abort; B column N-1 left untouched to see the cleared buffer
      for (int r = 0; r < N; r++) load(LD_SEL_A, r, LW'($urandom));
      for (int j = 0; j < N-1; j++) load(LD_SEL_B, j, LW'($urandom));
      run_job("post_rst", 1'b0, 0, 1'b0, 1'b0, LD_SEL_A, 0, '0);

`ifdef SYSTOLIC_FEEDER_ACCUM_EN
      for (int r = 0; r < N; r++) begin
         load(LD_SEL_A, r, fill(2, 0));
         load(LD_SEL_B, r, fill(3, 0));
      end
      run_job("acc_first", 1'b0, 0, 1'b0, 1'b0, LD_SEL_A, 0, '0);
      run_job("acc_second", 1'b1, 0, 1'b0, 1'b0, LD_SEL_A, 0, '0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Operand staging and skew stage directly upstream of the PE grid. It buffers one N x N tile of A (row-wise) and B (column-wise), then streams them diagonally skewed onto the west (a) and north (b) edges of an N x N array of PEs. It emits a one-cycle PE clear before each job and a done pulse once every accumulator holds its final value.

Parameters:
DATA_WIDTH, 8, operand width; equals PE DATA_WIDTH.
N, 4, array dimension, which is also the tile size and K depth. Legal range is N >= 2.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
ld_valid  in  1  load beat valid.
ld_ready  out  1  load beat accepted when ld_valid && ld_ready.
ld_sel  in  1  0 = A row, 1 = B column.
ld_idx  in  $clog2(N)  row index (A) or column index (B).
ld_data  in  N*DATA_WIDTH  element k in bits [k*DW +: DW]; A[idx][k] or B[k][idx].
start  in  1  begin job; sampled only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse; results stable on PE c_out.
array_clr  out  1  drives PE reset (active-high synchronous).
a_feed  out  N*DATA_WIDTH  lane i to PE row i, column 0 a_in.
b_feed  out  N*DATA_WIDTH  lane j to PE row 0, column j b_in.

Behaviour:
- While reset is low:
  - State is IDLE, the step counter is 0 and both buffers are 0.
  - done, array_clr, busy, a_feed and b_feed are 0.
  - ld_ready is 1 (it is combinational: state == IDLE).
- Reset mid-job aborts immediately. No done pulse is issued and buffers are cleared.
- States:
  - IDLE: accepts loads. On start -> CLEAR.
  - CLEAR: one cycle, array_clr = 1, feeds 0. -> STREAM, step t = 0.
  - STREAM: 2N-1 cycles, t = 0..2N-2. -> DRAIN.
  - DRAIN: N-1 cycles, t = 2N-1..3N-3, feeds 0. -> DONE.
  - DONE: one cycle, done = 1. -> IDLE.
- Feed rule: a_feed and b_feed are registered; the value shown applies during cycle t.
  - a_feed lane i = A[i][t-i] when 0 <= t-i < N, else 0.
  - b_feed lane j = B[t-j][j] when 0 <= t-j < N, else 0.
- Latency: start sampled at edge E means CLEAR is in cycle E+1, stream t=0 in E+2, and done in cycle E+3N.
  - The last product A[N-1][N-1]*B[N-1][N-1] reaches PE(N-1,N-1) at t = 3N-3 and is accumulated at that cycle's closing edge.
- Loads are accepted only in IDLE. ld_valid outside IDLE is not accepted and the buffers are unchanged.
- A load and start in the same IDLE cycle: the load is written and is used by the job, because CLEAR provides one cycle of margin.
- start outside IDLE is ignored and is not queued.
- Buffers persist across jobs, so a partial reload followed by start reuses the untouched rows and columns.
- Counter width is $clog2(3N). It must not wrap before 3N-3.

Optional Feature:
Macro SYSTOLIC_FEEDER_ACCUM_EN.
- Defined:
  - Adds input port accumulate (1 bit), sampled with start.
  - If accumulate = 1, IDLE -> STREAM directly, skipping CLEAR. array_clr stays 0, so the PEs add the new tile to existing sums (K-tiling).
  - done then arrives one cycle earlier, in cycle E+3N-1.
- Undefined: the port is absent and every job passes through CLEAR.

Decomposition:
- Shared package systolic_pkg holds:
  - the feeder state enum (IDLE, CLEAR, STREAM, DRAIN, DONE);
  - LD_SEL_A = 0 and LD_SEL_B = 1;
  - default DATA_WIDTH and N;
  - the derived STREAM_LEN = 2N-1 and DRAIN_LEN = N-1 expressions.
- One sub-module, systolic_skew_lane, is instantiated 2N times, once per a-lane and once per b-lane.
  - Inputs: a lane index, step t, an N-element vector.
  - Output: the skew-selected element or 0.

Test Plan:
- N=4, DW=8: load A row0 = {1,2,3,4}, then start -> a_feed lane0 = 1,2,3,4 at t = 0..3 and 0 at t = 4..6; lane1 is 0 at t = 0.
- Feeder connected to a 4x4 PE grid; A all 2, B all 3, start -> done at E+12 and every c_out = 24.
- A = identity, B[k][j] = 4k+j+1 -> on done, C equals B (c_out(0,3) = 4, c_out(3,0) = 13).
- ld_valid = 1 with new data while busy -> ld_ready = 0, buffers unchanged; a second job reproduces the first job's results.
- Reset low at stream t = 3 -> all outputs 0 and no done pulse. After release, reload and start complete normally.
- With SYSTOLIC_FEEDER_ACCUM_EN: job 1 (all 2 x 3), then job 2 with accumulate = 1 (same data) -> c_out = 48, array_clr never high during job 2, done at E+11.
